div_seq_ctrl: RTL and testbench

- Sequencer for the iterative radix-2 divider shared with the integer register-file read path.
- Accepts one DIV/DIVU/REM/REMU issue from decode and stalls the front end while busy.
- Drives datapath controls: load, per-iteration step, sign-fix cycle and result-select mux.
- Short-circuits the RISC-V special cases (divide-by-zero, signed overflow), then holds a writeback request until accepted.

---
 rtl/div_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Control sequencer for the shared iterative radix-2 divider (DIV/DIVU/REM/REMU).
// Optional build macro DIV_EARLY_OUT_EN: unsigned ops skip leading-zero iterations of rs1.
module div_seq_ctrl #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_v,
    input  logic [2:0]    funct3,
    input  logic [4:0]    rd,
    input  logic          rs2_zero,
    input  logic          ovf,
    input  logic          rs1_neg,
    input  logic          rs2_neg,
    input  logic [CW:0]   rs1_lz,
    input  logic          flush,
    input  logic          wb_ready,
    output logic          stall,
    output logic          load,
    output logic          step,
    output logic [CW-1:0] count,
    output logic          fix,
    output logic [2:0]    sel,
    output logic          wb_v,
    output logic [4:0]    wb_rd
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [2:0]    SEL_Q    = 3'd0;
    localparam logic [2:0]    SEL_REM  = 3'd1;
    localparam logic [2:0]    SEL_ONES = 3'd2;
    localparam logic [2:0]    SEL_RS1  = 3'd3;
    localparam logic [2:0]    SEL_ZERO = 3'd4;
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    sel_q, sel_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          need_fix_q, need_fix_d;

    logic          is_rem_s;
    logic          is_signed_s;
    logic [CW-1:0] start_cnt_s;
    logic          unused_ok_s;

    assign is_rem_s    = funct3[1];
    assign is_signed_s = ~funct3[0];

`ifdef DIV_EARLY_OUT_EN
    localparam logic [CW:0] LZ_CAP = (CW + 1)'(XLEN - 1);

    // First iteration index for unsigned ops: skip rs1's leading zeros, capped at the last index
    always_comb begin
        start_cnt_s = '0;
        if (funct3[0] && (rs1_lz != '0)) begin
            if (rs1_lz > LZ_CAP) begin
                start_cnt_s = LAST_CNT;
            end else begin
                start_cnt_s = rs1_lz[CW-1:0];
            end
        end else begin
            start_cnt_s = '0;
        end
    end

    assign unused_ok_s = funct3[2];
`else
    assign start_cnt_s = '0;
    assign unused_ok_s = ^{funct3[2], rs1_lz};
`endif

    // Next-state and held-field logic; flush always wins over any forward progress
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sel_d      = sel_q;
        wb_rd_d    = wb_rd_q;
        need_fix_d = need_fix_q;
        case (state_q)
            S_IDLE: begin
                if (issue_v && !flush) begin
                    wb_rd_d    = rd;
                    need_fix_d = is_signed_s & ~rs2_zero
                               & (is_rem_s ? rs1_neg : (rs1_neg ^ rs2_neg));
                    if (rs2_zero) begin
                        sel_d   = is_rem_s ? SEL_RS1 : SEL_ONES;
                        count_d = '0;
                        state_d = S_WB;
                    end else if (ovf && is_signed_s) begin
                        sel_d   = is_rem_s ? SEL_ZERO : SEL_RS1;
                        count_d = '0;
                        state_d = S_WB;
                    end else begin
                        sel_d   = is_rem_s ? SEL_REM : SEL_Q;
                        count_d = start_cnt_s;
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (flush) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (flush) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (count_q == LAST_CNT) begin
                    count_d = '0;
                    state_d = need_fix_q ? S_FIX : S_WB;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            default: begin
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and held-field registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            sel_q      <= 3'd0;
            wb_rd_q    <= 5'd0;
            need_fix_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sel_q      <= sel_d;
            wb_rd_q    <= wb_rd_d;
            need_fix_q <= need_fix_d;
        end
    end

    // Datapath strobes are killed in the flush cycle itself so a flushed WB never retires
    assign stall = (state_q != S_IDLE) | issue_v;
    assign load  = (state_q == S_LOAD) & ~flush;
    assign step  = (state_q == S_ITER) & ~flush;
    assign fix   = (state_q == S_FIX) & ~flush;
    assign wb_v  = (state_q == S_WB) & ~flush;
    assign count = count_q;
    assign sel   = sel_q;
    assign wb_rd = wb_rd_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table, random ops against a latency model, abort sequences.
module tb_div_seq_ctrl;
    localparam int XLEN = 32;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          reset, issue_v, rs2_zero, ovf, rs1_neg, rs2_neg, flush, wb_ready;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic [CW:0]   rs1_lz;
    logic          stall, load, step, fix, wb_v;
    logic [CW-1:0] count;
    logic [2:0]    sel;
    logic [4:0]    wb_rd;

    int tests = 0;
    int fails = 0;

    div_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .issue_v(issue_v), .funct3(funct3), .rd(rd),
        .rs2_zero(rs2_zero), .ovf(ovf), .rs1_neg(rs1_neg), .rs2_neg(rs2_neg),
        .rs1_lz(rs1_lz), .flush(flush), .wb_ready(wb_ready), .stall(stall),
        .load(load), .step(step), .count(count), .fix(fix), .sel(sel),
        .wb_v(wb_v), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] f3;
        logic [4:0] rd;
        bit         z;
        bit         ovf;
        bit         n1;
        bit         n2;
        int         lz;
        int         lat;
        int         sel;
        bit         fix;
        int         steps;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: result select and cycles-to-writeback from the ISA special-case rules
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   is_rem;
        bit   sgn;
        int   start;
        r      = v;
        is_rem = v.f3[1];
        sgn    = ~v.f3[0];
        start  = 0;
        if (v.z) begin
            r.lat = 1; r.sel = is_rem ? 3 : 2; r.fix = 1'b0; r.steps = 0;
        end else if (v.ovf && sgn) begin
            r.lat = 1; r.sel = is_rem ? 4 : 3; r.fix = 1'b0; r.steps = 0;
        end else begin
`ifdef DIV_EARLY_OUT_EN
            if (!sgn && v.lz > 0) start = (v.lz > XLEN - 1) ? XLEN - 1 : v.lz;
`endif
            r.steps = XLEN - start;
            r.fix   = sgn && (is_rem ? v.n1 : (v.n1 ^ v.n2));
            r.sel   = is_rem ? 1 : 0;
            r.lat   = r.steps + 2 + int'(r.fix);
        end
        return r;
    endfunction

    task automatic watch_quiet(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (load || step || fix || wb_v || stall) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic run_op(input vec_t v, input int wb_delay, input bit extra_issue);
        int load_cyc, fix_cyc, wb_cyc, ret_cyc, steps, cnt_err, hold_err, exp_cnt, start;
        logic [2:0] sel0;
        logic [4:0] rd0;
        start    = (v.steps > 0) ? (XLEN - v.steps) : 0;
        load_cyc = -1; fix_cyc = -1; wb_cyc = -1; ret_cyc = -1;
        steps = 0; cnt_err = 0; hold_err = 0; exp_cnt = start;
        sel0 = 3'd0; rd0 = 5'd0;
        @(negedge clk);
        issue_v = 1'b1; funct3 = v.f3; rd = v.rd; rs2_zero = v.z; ovf = v.ovf;
        rs1_neg = v.n1; rs2_neg = v.n2; rs1_lz = 6'(v.lz); wb_ready = (wb_delay == 0);
        #1 check("stall_in_issue_cycle", int'(stall), 1);
        for (int cyc = 1; cyc <= 80 && ret_cyc < 0; cyc++) begin
            @(negedge clk);
            if (load) begin
                if (load_cyc < 0) load_cyc = cyc;
                if (int'(count) != start) cnt_err++;
            end else if (step) begin
                steps++;
                if (int'(count) != exp_cnt) cnt_err++;
                exp_cnt++;
            end else if (count != '0) begin
                cnt_err++;
            end
            if (fix && fix_cyc < 0) fix_cyc = cyc;
            issue_v = 1'b0;
            if (wb_v) begin
                if (wb_cyc < 0) begin
                    wb_cyc = cyc; sel0 = sel; rd0 = wb_rd;
                end else if (sel != sel0 || wb_rd != rd0 || !stall) begin
                    hold_err++;
                end
                if (extra_issue && cyc == wb_cyc + 1) begin
                    issue_v = 1'b1; rd = ~v.rd;
                end
                wb_ready = (cyc >= wb_cyc + wb_delay);
                if (wb_ready) ret_cyc = cyc;
            end
        end
        @(negedge clk);
        check("stall_after_retire", int'(stall), 0);
        check("wb_v_after_retire", int'(wb_v), 0);
        issue_v = 1'b0; wb_ready = 1'b0;
        check("load_cycle", load_cyc, (v.steps > 0) ? 1 : -1);
        check("step_count", steps, v.steps);
        check("count_sequence_errs", cnt_err, 0);
        check("fix_cycle", fix_cyc, v.fix ? v.lat - 1 : -1);
        check("wb_latency", wb_cyc, v.lat);
        check("wb_sel", int'(sel0), v.sel);
        check("wb_rd", int'(rd0), int'(v.rd));
        check("wb_hold_errs", hold_err, 0);
        check("retire_cycle", ret_cyc, v.lat + wb_delay);
        if (extra_issue) watch_quiet(4, "ignored_issue_quiet");
    endtask

    task automatic start_divu_to_count10(input logic [4:0] dst);
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        issue_v = 1'b1; funct3 = 3'b101; rd = dst; rs2_zero = 1'b0; ovf = 1'b0;
        rs1_neg = 1'b0; rs2_neg = 1'b0; rs1_lz = 6'd0; wb_ready = 1'b1;
        @(negedge clk);
        issue_v = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (step && count == 5'd10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_count10", int'(hit), 1);
    endtask

    vec_t tbl[14];
    vec_t v;

    initial begin
        //        f3      rd     z     ovf   n1    n2   lz  lat sel fix  steps
        tbl[0]  = '{3'b101, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 0, 34, 0, 1'b0, 32};
        tbl[1]  = '{3'b100, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 0, 35, 0, 1'b1, 32};
        tbl[2]  = '{3'b110, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 0, 34, 1, 1'b0, 32};
        tbl[3]  = '{3'b111, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1,  3, 1'b0, 0};
        tbl[4]  = '{3'b100, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1,  2, 1'b0, 0};
        tbl[5]  = '{3'b100, 5'd13, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1,  3, 1'b0, 0};
        tbl[6]  = '{3'b110, 5'd15, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1,  4, 1'b0, 0};
        tbl[7]  = '{3'b101, 5'd17, 1'b0, 1'b1, 1'b1, 1'b0, 0, 34, 0, 1'b0, 32};
        tbl[8]  = '{3'b110, 5'd19, 1'b0, 1'b0, 1'b1, 1'b1, 0, 35, 1, 1'b1, 32};
        tbl[9]  = '{3'b100, 5'd21, 1'b0, 1'b0, 1'b1, 1'b1, 0, 34, 0, 1'b0, 32};
        tbl[10] = '{3'b100, 5'd23, 1'b0, 1'b0, 1'b0, 1'b0, 20, 34, 0, 1'b0, 32};
`ifdef DIV_EARLY_OUT_EN
        tbl[11] = '{3'b101, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 20, 14, 0, 1'b0, 12};
`else
        tbl[11] = '{3'b101, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 20, 34, 0, 1'b0, 32};
`endif
        tbl[12] = '{3'b111, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 0, 1,  3, 1'b0, 0};
        tbl[13] = '{3'b100, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 0, 1,  2, 1'b0, 0};

        reset = 1'b1; issue_v = 1'b0; funct3 = 3'b000; rd = 5'd0; rs2_zero = 1'b0;
        ovf = 1'b0; rs1_neg = 1'b0; rs2_neg = 1'b0; rs1_lz = 6'd0; flush = 1'b0; wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", int'({stall, load, step, count, fix, sel, wb_v, wb_rd}), 0);

        for (int i = 0; i < 14; i++) run_op(tbl[i], i % 3, 1'b0);

        // Backpressure: five cycles of wb_ready=0 plus a stray issue that must be ignored
        v = tbl[0];
        v.rd = 5'd12;
        run_op(v, 5, 1'b1);

        for (int i = 0; i < 25; i++) begin
            v.f3  = 3'($urandom_range(4, 7));
            v.rd  = 5'($urandom_range(0, 31));
            v.z   = ($urandom_range(0, 3) == 0);
            v.ovf = ($urandom_range(0, 3) == 0);
            v.n1  = 1'($urandom_range(0, 1));
            v.n2  = 1'($urandom_range(0, 1));
            v.lz  = $urandom_range(0, 63);
            v     = model(v);
            run_op(v, $urandom_range(0, 3), 1'b0);
        end

        // Flush mid-ITER
        start_divu_to_count10(5'd25);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        watch_quiet(40, "flush_iter_quiet");

        // Reset mid-ITER
        start_divu_to_count10(5'd27);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_iter_regs", int'({count, sel, wb_rd, wb_v}), 0);
        watch_quiet(40, "reset_iter_quiet");

        // Flush together with wb_ready in WB drops the result
        @(negedge clk);
        issue_v = 1'b1; funct3 = 3'b111; rd = 5'd6; rs2_zero = 1'b1; wb_ready = 1'b0;
        @(negedge clk);
        issue_v = 1'b0; rs2_zero = 1'b0;
        check("wb_before_flush", int'(wb_v), 1);
        flush = 1'b1; wb_ready = 1'b1;
        #1 check("wb_v_in_flush_cycle", int'(wb_v), 0);
        @(posedge clk);
        #1 flush = 1'b0; wb_ready = 1'b0;
        watch_quiet(5, "flush_wb_quiet");

        // Flush together with issue in IDLE: nothing starts
        @(negedge clk);
        issue_v = 1'b1; flush = 1'b1; funct3 = 3'b101; rd = 5'd8;
        @(posedge clk);
        #1 issue_v = 1'b0; flush = 1'b0;
        watch_quiet(5, "flush_issue_quiet");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
